addsub_pipe: RTL and testbench

- Parametrised, pipelined successor of the team's registered 8-bit add/subtract unit.
- Computes add, subtract, or a running accumulation on WIDTH-bit unsigned operands.
- Produces a WIDTH+1-bit result (carry/borrow in the MSB) with an optional saturation mode.
- Sits between a valid/ready producer and consumer, with full backpressure and a configurable pipeline depth.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/addsub_pipe_stage.sv | 42 ++++
 rtl/addsub_pipe.sv | 138 +++++++++++++
 tb/tb_addsub_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract/accumulate unit.
package addsub_pkg;

   // Operation encoding presented on the op port.
   typedef enum logic [1:0] {
      OP_SUB      = 2'b00,
      OP_ADD      = 2'b01,
      OP_ACC_ADD  = 2'b10,
      OP_ACC_LOAD = 2'b11
   } op_t;

   // Widest operand supported; sat_max returns a value this many bits plus one.
   localparam int MAX_WIDTH = 32;

   // All-ones constant of the given width, right-aligned in MAX_WIDTH+1 bits.
   // A width of MAX_WIDTH+1 shifts the one out completely, so the subtraction
   // still yields the full all-ones word.
   function automatic logic [MAX_WIDTH:0] sat_max(input int width);
      return (33'd1 << width) - 33'd1;
   endfunction

endpackage

// File: rtl/addsub_pipe_stage.sv
// One delay stage of the result pipeline: carries valid, result and overflow
// forward whenever the whole pipeline advances.
module addsub_pipe_stage
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_advance,
   input  logic             i_valid,
   input  logic [WIDTH:0]   i_result,
   input  logic             i_overflow,
   output logic             o_valid,
   output logic [WIDTH:0]   o_result,
   output logic             o_overflow
);

   logic             r_valid;
   logic [WIDTH:0]   r_result;
   logic             r_overflow;

   // Shift the previous stage in on advance, otherwise hold (bubbles included).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments here so every stage samples the
         // pre-edge value of its neighbour, independent of evaluation order.
         r_valid    <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
      end else if (i_advance) begin
         r_valid    <= i_valid;
         r_result   <= i_result;
         r_overflow <= i_overflow;
      end
   end

   assign o_valid    = r_valid;
   assign o_result   = r_result;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add / subtract / accumulate unit with valid-ready handshakes.
// All arithmetic happens in stage 0 at acceptance; LATENCY-1 delay stages
// follow. The whole pipeline stalls together when the consumer holds off.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   input  logic [1:0]       op,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic             overflow
);

   localparam logic [MAX_WIDTH:0] L_ONES_W  = sat_max(WIDTH);
   localparam logic [MAX_WIDTH:0] L_ONES_W1 = sat_max(WIDTH + 1);

   logic             w_advance;
   logic             w_accept;
   op_t              w_op;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH+1:0] w_acc_sum;
   logic [WIDTH:0]   w_next_result;
   logic             w_next_overflow;
   logic [WIDTH:0]   w_next_acc;

   logic             r_s0_valid;
   logic [WIDTH:0]   r_s0_result;
   logic             r_s0_overflow;
   logic [WIDTH:0]   r_acc;

   logic             w_valid    [LATENCY];
   logic [WIDTH:0]   w_result   [LATENCY];
   logic             w_overflow [LATENCY];

   // The pipeline moves whenever the output slot is empty or being drained.
   assign w_advance = out_ready || !out_valid;
   assign in_ready  = w_advance;
   assign w_accept  = in_valid && w_advance;
   assign w_op      = op_t'(op);

   assign w_sum     = {1'b0, dataa} + {1'b0, datab};
   assign w_diff    = {1'b0, dataa} - {1'b0, datab};
   assign w_acc_sum = {1'b0, r_acc} + {2'b00, dataa};

   // Select this beat's result, overflow flag and next accumulator value.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch
      // is inferred when a case arm leaves a signal untouched.
      w_next_result   = '0;
      w_next_overflow = 1'b0;
      w_next_acc      = r_acc;
      case (w_op)
         OP_ADD: begin
            w_next_overflow = w_sum[WIDTH];
            w_next_result   = (sat && w_sum[WIDTH]) ? L_ONES_W[WIDTH:0] : w_sum;
         end
         OP_SUB: begin
            w_next_overflow = w_diff[WIDTH];
            w_next_result   = (sat && w_diff[WIDTH]) ? '0 : w_diff;
         end
         OP_ACC_ADD: begin
            w_next_overflow = w_acc_sum[WIDTH+1];
            w_next_acc      = (sat && w_acc_sum[WIDTH+1]) ? L_ONES_W1[WIDTH:0]
                                                          : w_acc_sum[WIDTH:0];
            w_next_result   = w_next_acc;
         end
         OP_ACC_LOAD: begin
            w_next_acc    = {1'b0, dataa};
            w_next_result = {1'b0, dataa};
         end
         default: begin
            w_next_result = '0;
         end
      endcase
   end

   // Compute stage: valid follows in_valid on advance, data loads on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0_valid    <= 1'b0;
         r_s0_result   <= '0;
         r_s0_overflow <= 1'b0;
      end else begin
         if (w_advance) begin
            r_s0_valid <= in_valid;
         end
         if (w_accept) begin
            r_s0_result   <= w_next_result;
            r_s0_overflow <= w_next_overflow;
         end
      end
   end

   // Accumulator changes only on an accepted beat, so stalled ACC ops are inert.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (w_accept) begin
         r_acc <= w_next_acc;
      end
   end

   assign w_valid[0]    = r_s0_valid;
   assign w_result[0]   = r_s0_result;
   assign w_overflow[0] = r_s0_overflow;

   for (genvar g = 1; g < LATENCY; g++) begin : g_stage
      addsub_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_advance  (w_advance),
         .i_valid    (w_valid[g-1]),
         .i_result   (w_result[g-1]),
         .i_overflow (w_overflow[g-1]),
         .o_valid    (w_valid[g]),
         .o_result   (w_result[g]),
         .o_overflow (w_overflow[g])
      );
   end

   assign out_valid = w_valid[LATENCY-1];
   assign result    = w_result[LATENCY-1];
   assign overflow  = w_overflow[LATENCY-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: a LATENCY=1 and a LATENCY=3 instance share stimulus.
// A background scoreboard models every accepted beat; directed checks cover
// latency, stalls, accumulator chaining and mid-stream reset.
module tb_addsub_pipe;
   import addsub_pkg::*;

   localparam int W     = 8;
   localparam int MAX_A = (1 << W) - 1;
   localparam int MAX_R = (1 << (W + 1)) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] dataa = '0;
   logic [W-1:0] datab = '0;
   logic [1:0]   op = 2'b00;
   logic         sat = 1'b0;
   logic         out_ready = 1'b1;

   logic         in_ready1, out_valid1, overflow1;
   logic [W:0]   result1;
   logic         in_ready3, out_valid3, overflow3;
   logic [W:0]   result3;

   always #5 clk = ~clk;

   addsub_pipe #(.WIDTH(W), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .dataa(dataa), .datab(datab), .op(op), .sat(sat),
      .out_valid(out_valid1), .out_ready(out_ready),
      .result(result1), .overflow(overflow1)
   );

   addsub_pipe #(.WIDTH(W), .LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
      .dataa(dataa), .datab(datab), .op(op), .sat(sat),
      .out_valid(out_valid3), .out_ready(out_ready),
      .result(result3), .overflow(overflow3)
   );

   typedef struct {
      logic [W:0] res;
      logic       ovf;
   } exp_t;

   typedef struct {
      op_t        op;
      logic       sat;
      int         a;
      int         b;
      logic [W:0] res;
      logic       ovf;
   } vec_t;

   exp_t q1[$];
   exp_t q3[$];
   int   macc1 = 0;
   int   macc3 = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference arithmetic in plain integers.
   function automatic exp_t model(input op_t o, input logic s, input int a, input int b,
                                  input int acc_in, output int acc_out);
      exp_t e;
      int   r;
      acc_out = acc_in;
      e.ovf   = 1'b0;
      case (o)
         OP_ADD: begin
            r     = a + b;
            e.ovf = (r > MAX_A);
            if (s && r > MAX_A) r = MAX_A;
         end
         OP_SUB: begin
            r     = a - b;
            e.ovf = (r < 0);
            if (r < 0) r = s ? 0 : r + MAX_R + 1;
         end
         OP_ACC_ADD: begin
            r     = acc_in + a;
            e.ovf = (r > MAX_R);
            if (r > MAX_R) r = s ? MAX_R : r - (MAX_R + 1);
            acc_out = r;
         end
         default: begin
            r       = a;
            acc_out = a;
         end
      endcase
      e.res = (W+1)'(r);
      return e;
   endfunction

   // Scoreboard: inputs are stable between posedge+1 and the next posedge, so
   // the negedge sees exactly what the coming edge will transfer.
   always @(negedge clk) begin
      exp_t e;
      int   nacc;
      if (!rst_n) begin
         q1.delete();
         q3.delete();
         macc1 = 0;
         macc3 = 0;
      end else begin
         if (out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb1_extra: got %0h expected none", result1);
            end else begin
               e = q1.pop_front();
               check("sb1", 32'({overflow1, result1}), 32'({e.ovf, e.res}));
            end
         end
         if (out_valid3 && out_ready) begin
            if (q3.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb3_extra: got %0h expected none", result3);
            end else begin
               e = q3.pop_front();
               check("sb3", 32'({overflow3, result3}), 32'({e.ovf, e.res}));
            end
         end
         if (in_valid && in_ready1) begin
            q1.push_back(model(op_t'(op), sat, int'(dataa), int'(datab), macc1, nacc));
            macc1 = nacc;
         end
         if (in_valid && in_ready3) begin
            q3.push_back(model(op_t'(op), sat, int'(dataa), int'(datab), macc3, nacc));
            macc3 = nacc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input op_t o, input logic s, input int a, input int b);
      op       = o;
      sat      = s;
      dataa    = a[W-1:0];
      datab    = b[W-1:0];
      in_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[$];
      exp_t he;
      logic hold;
      logic acc3;
      int   sent;
      int   n1;
      int   n3;

      // Single-cycle vectors checked on the LATENCY=1 instance.
      vecs.push_back('{OP_ADD,      1'b0, 200, 100, 9'h12C, 1'b1});
      vecs.push_back('{OP_SUB,      1'b0,   5,   7, 9'h1FE, 1'b1});
      vecs.push_back('{OP_ADD,      1'b1, 200, 100, 9'h0FF, 1'b1});
      vecs.push_back('{OP_SUB,      1'b1,   5,   7, 9'h000, 1'b1});
      vecs.push_back('{OP_ADD,      1'b1,   3,   4, 9'h007, 1'b0});
      vecs.push_back('{OP_ADD,      1'b0, 255,   0, 9'h0FF, 1'b0});
      vecs.push_back('{OP_SUB,      1'b0,   9,   9, 9'h000, 1'b0});
      vecs.push_back('{OP_ACC_LOAD, 1'b0, 250,   0, 9'h0FA, 1'b0});
      vecs.push_back('{OP_ACC_ADD,  1'b0, 200,   0, 9'h1C2, 1'b0});
      vecs.push_back('{OP_ACC_ADD,  1'b0, 100,   0, 9'h026, 1'b1});
      vecs.push_back('{OP_ACC_LOAD, 1'b1, 250,   0, 9'h0FA, 1'b0});
      vecs.push_back('{OP_ACC_ADD,  1'b1, 200,   0, 9'h1C2, 1'b0});
      vecs.push_back('{OP_ACC_ADD,  1'b1, 100,   0, 9'h1FF, 1'b1});

      // Reset state.
      #1 rst_n = 1'b0;
      #1;
      check("rst_out1", 32'({out_valid1, overflow1, result1}), 32'(0));
      check("rst_out3", 32'({out_valid3, overflow3, result3}), 32'(0));
      #10 rst_n = 1'b1;
      #1;
      check("rst_ready1", 32'(in_ready1), 32'(1));
      check("rst_ready3", 32'(in_ready3), 32'(1));
      tick();

      // Table vectors, back to back, one per cycle.
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].sat, vecs[i].a, vecs[i].b);
         tick();
         check($sformatf("vec%0d", i), 32'({out_valid1, overflow1, result1}),
               32'({1'b1, vecs[i].ovf, vecs[i].res}));
      end
      idle(4);

      // LATENCY=3 streaming: first output two edges after first acceptance.
      for (int e = 1; e <= 8; e++) begin
         if (e <= 6) drive(OP_ADD, 1'b0, e - 1, e - 1);
         else in_valid = 1'b0;
         tick();
         if (e >= 3)
            check($sformatf("stream%0d", e), 32'({out_valid3, overflow3, result3}),
                  32'({1'b1, 1'b0, 9'(2 * (e - 3))}));
         else
            check($sformatf("stream%0d", e), 32'(out_valid3), 32'(0));
      end
      idle(4);

      // Toggled out_ready: ordered delivery and held outputs while stalled.
      sent = 0;
      for (int c = 0; c < 40 && (sent < 6 || q3.size() > 0); c++) begin
         out_ready = (c % 2 == 0);
         if (sent < 6) drive(OP_ADD, 1'b0, sent + 10, sent);
         else in_valid = 1'b0;
         #1;
         hold = out_valid3 && !out_ready && (q3.size() > 0);
         if (hold) he = q3[0];
         acc3 = in_valid && in_ready3;
         tick();
         if (acc3) sent++;
         if (hold)
            check("hold", 32'({out_valid3, overflow3, result3}), 32'({1'b1, he.ovf, he.res}));
      end
      check("toggle_sent", 32'(sent), 32'(6));
      check("toggle_drain", 32'(q3.size()), 32'(0));
      out_ready = 1'b1;
      idle(4);

      // Backpressure with ACC_ADD held: only LATENCY beats get in.
      drive(OP_ACC_LOAD, 1'b0, 0, 0);
      tick();
      idle(4);
      out_ready = 1'b0;
      n1 = 0;
      n3 = 0;
      repeat (5) begin
         drive(OP_ACC_ADD, 1'b0, 1, 0);
         #1;
         if (in_ready1) n1++;
         if (in_ready3) n3++;
         tick();
      end
      check("bp_accept1", 32'(n1), 32'(1));
      check("bp_accept3", 32'(n3), 32'(3));
      out_ready = 1'b1;
      idle(5);
      drive(OP_ACC_ADD, 1'b0, 0, 0);
      tick();
      in_valid = 1'b0;
      check("bp_acc1", 32'({out_valid1, overflow1, result1}), 32'({1'b1, 1'b0, 9'd1}));
      tick();
      tick();
      check("bp_acc3", 32'({out_valid3, overflow3, result3}), 32'({1'b1, 1'b0, 9'd3}));
      idle(4);

      // Reset with three beats stalled in flight.
      out_ready = 1'b0;
      repeat (3) begin
         drive(OP_ADD, 1'b0, 1, 2);
         tick();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out1", 32'({out_valid1, overflow1, result1}), 32'(0));
      check("midrst_out3", 32'({out_valid3, overflow3, result3}), 32'(0));
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("midrst_ready3", 32'(in_ready3), 32'(1));
      tick();
      drive(OP_ACC_ADD, 1'b0, 1, 0);
      tick();
      in_valid = 1'b0;
      check("midrst_acc1", 32'({out_valid1, overflow1, result1}), 32'({1'b1, 1'b0, 9'd1}));
      tick();
      tick();
      check("midrst_acc3", 32'({out_valid3, overflow3, result3}), 32'({1'b1, 1'b0, 9'd1}));

      idle(6);
      check("final_q1", 32'(q1.size()), 32'(0));
      check("final_q3", 32'(q3.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
